uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16; number of byte entries, power of two, minimum 2.
REQ-002 Parameter AFULL_LVL, default 12; o_almost_full asserts when occupancy is at or above this value; range 1..DEPTH.
REQ-003 i_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_rx_byte  input  8  received byte from the UART receiver.
REQ-006 i_rx_dv  input  1  one-cycle strobe; i_rx_byte is valid in this cycle.
REQ-007 i_rd_en  input  1  pop request from the consumer.
REQ-008 o_rd_data  output  8  head-of-queue byte, show-ahead.
REQ-009 o_empty  output  1  queue holds zero bytes.
REQ-010 o_full  output  1  queue holds DEPTH bytes.
REQ-011 o_almost_full  output  1  occupancy >= AFULL_LVL.
REQ-012 o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 i_ovf_clr  input  1  clears o_overflow.
REQ-014 o_overflow  output  1  sticky flag; at least one byte was dropped.

Function
REQ-015 Write: i_rx_dv=1 and not full stores i_rx_byte at the write pointer; the write pointer advances by one, modulo DEPTH.
REQ-016 Read: i_rd_en=1 and not empty advances the read pointer by one, modulo DEPTH; i_rd_en while empty is ignored, with no state change.
REQ-017 o_rd_data shows the entry at the read pointer whenever o_empty=0, and shows 8'h00 whenever o_empty=1.
REQ-018 Latency: a byte written at edge N appears on o_rd_data, with o_empty=0, in the cycle after edge N (one cycle).
REQ-019 o_count changes per edge as follows: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-020 o_empty, o_full and o_almost_full are registered, or derived from registered o_count only; they never glitch on inputs.
REQ-021 Simultaneous write and read while full: both are accepted, o_count stays at DEPTH, and o_overflow is not set.
REQ-022 Simultaneous write and read while empty: only the write takes effect, and o_count becomes 1.
REQ-023 Overflow: i_rx_dv=1 while full and i_rd_en=0 drops the byte, leaves memory and pointers untouched, and sets o_overflow at that edge.
REQ-024 o_overflow stays at 1 until an edge with i_ovf_clr=1; if a set and a clear occur on the same edge, the set wins.
REQ-025 Pointer wrap: after DEPTH writes and DEPTH reads, both pointers return to 0 and data order is preserved; strict FIFO order holds across wrap.
REQ-026 Storage contents are not reset; only pointers, count and flags are reset.

Reset
REQ-027 While i_rst_n=0, immediately and independent of i_clk: o_count=0, o_empty=1, o_full=0, o_almost_full=0, o_overflow=0, o_rd_data=8'h00, pointers=0.
REQ-028 Reset asserted mid-operation discards all queued bytes.
REQ-029 After reset deasserts, the first rising edge with i_rx_dv=1 is accepted as a normal write.

Structure
REQ-030 Shared package: the byte width constant UART_DATA_W=8, and the count-width function or macro $clog2(DEPTH)+1; this package is shared with the receiver and transmitter.
REQ-031 One sub-module, uart_fifo_mem: a DEPTH x 8 array with synchronous write and asynchronous read, and no reset.
REQ-032 Pointer, count, flag and overflow logic reside in uart_rx_fifo.

Verification
REQ-033 Single byte: push 8'hA5 with one i_rx_dv pulse -> next cycle o_empty=0, o_rd_data=8'hA5, o_count=1; pulse i_rd_en -> o_empty=1, o_rd_data=8'h00.
REQ-034 Fill and overflow (DEPTH=16): push 8'h00..8'h0F -> o_full=1 and o_almost_full=1 (asserting from count 12); push 8'hFF -> o_overflow=1 and o_count=16; pop all -> 8'h00..8'h0F in order, 8'hFF absent.
REQ-035 Simultaneous push/pop when full: push 8'h55 with i_rd_en=1 -> o_count stays 16, o_overflow=0, head advances; 8'h55 emerges as the 16th pop.
REQ-036 Wrap: 40 interleaved push/pop pairs of an incrementing pattern -> every popped byte equals the expected sequence value, and o_count never exceeds 2.
REQ-037 Sticky clear: overflow set, then i_ovf_clr=1 on the same edge as another overflowing push -> o_overflow remains 1; a following lone clear -> o_overflow=0.
REQ-038 Reset mid-stream: 5 bytes queued, pulse i_rst_n low between clock edges -> all outputs reach reset values without a clock; a push of 8'h3C afterwards is read back as the sole byte.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: byte width and FIFO occupancy-counter sizing.
// Used by the receive FIFO, the receiver and the transmitter.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W = 8;

    // Occupancy runs 0..depth inclusive, so it needs one bit more than a pointer.
    function automatic int fifo_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte storage for the UART receive FIFO.
// Synchronous write, asynchronous (show-ahead) read.
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [AW-1:0]          i_waddr,
    input  logic [UART_DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]          i_raddr,
    output logic [UART_DATA_W-1:0] o_rdata
);

    logic [UART_DATA_W-1:0] mem [DEPTH];

    // NOTE: no reset on the array; contents are only meaningful between the
    // pointers, and leaving it unreset lets synthesis map it to RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and its consumer.
// Show-ahead read, registered occupancy/flags, sticky overflow on dropped bytes.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12,
    localparam int CNT_W    = fifo_count_w(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [UART_DATA_W-1:0] i_rx_byte,
    input  logic                   i_rx_dv,
    input  logic                   i_rd_en,
    input  logic                   i_ovf_clr,
    output logic [UART_DATA_W-1:0] o_rd_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_almost_full,
    output logic [CNT_W-1:0]       o_count,
    output logic                   o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   wr_fire;
    logic                   rd_fire;
    logic                   ovf_set;
    logic [UART_DATA_W-1:0] mem_rdata;

    // Flags depend only on the registered count, so they cannot glitch on inputs.
    assign o_empty       = (count == '0);
    assign o_full        = (count == CNT_W'(DEPTH));
    assign o_almost_full = (count >= CNT_W'(AFULL_LVL));
    assign o_count       = count;

    // A write while full is still accepted when a read frees the head slot in the same edge.
    assign wr_fire = i_rx_dv && (!o_full || i_rd_en);
    assign rd_fire = i_rd_en && !o_empty;
    assign ovf_set = i_rx_dv && o_full && !i_rd_en;

    assign o_rd_data = o_empty ? '0 : mem_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_fire && !rd_fire) begin
                count <= count + CNT_W'(1);
            end else if (rd_fire && !wr_fire) begin
                count <= count - CNT_W'(1);
            end
            // Set has priority over clear so a drop on the clearing edge is never lost.
            if (ovf_set) begin
                o_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                o_overflow <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr_fire),
        .i_waddr (wr_ptr),
        .i_wdata (i_rx_byte),
        .i_raddr (rd_ptr),
        .o_rdata (mem_rdata)
    );

endmodule
